// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: exception cause codes, the trap
// vector and the exception FSM state encoding.
package mips_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
  localparam logic [4:0]  CAUSE_OVF      = 5'd12;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HOLD = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl.sv
// Exception controller for the EX/MEM stage: captures overflow traps into
// EPC/cause, raises a one-cycle flush/redirect, then holds until acknowledged.
module exc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned    DATA_W    = 32,
  parameter logic [4:0]     OVF_CAUSE = CAUSE_OVF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              trap,
  input  logic [DATA_W-1:0] trap_pc,
  input  logic              exc_ack,
  output exc_state_e        state_o,
  output logic              flush_req,
  output logic              exc_pending,
  output logic              exc_redirect,
  output logic [DATA_W-1:0] epc,
  output logic [4:0]        exc_cause
);

  exc_state_e        state_q, state_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [4:0]        cause_q, cause_d;

  // State and trap-record registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; a stall in TRAP defers the redirect by holding the state
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      RUN: begin
        if (trap) begin
          state_d = TRAP;
          epc_d   = trap_pc;
          cause_d = OVF_CAUSE;
        end
      end
      TRAP:    if (!stall) state_d = HOLD;
      HOLD:    if (exc_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    flush_req    = (state_q == TRAP) && !stall;
    exc_redirect = (state_q == TRAP) && !stall;
    exc_pending  = (state_q == HOLD);
  end

  assign state_o   = state_q;
  assign epc       = epc_q;
  assign exc_cause = cause_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves final write enable, branch redirect and
// overflow traps. Optional EX_MEM_STATS_EN adds retired/trap counters.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [4:0]        OVF_CAUSE  = CAUSE_OVF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_alu_zero,
  input  logic              ex_movn,
  input  logic              ex_overflow,
  input  logic              ex_is_branch,
  input  logic              ex_is_movn,
  input  logic              ex_trap_ovf,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_dest_reg,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_dest_reg,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush_req,
  output logic              exc_pending,
  output logic [DATA_W-1:0] epc,
  output logic [4:0]        exc_cause
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [15:0]       ovf_trap_cnt
`endif
);

  exc_state_e        exc_state;
  logic              exc_redirect;
  logic              load, slot_live, trap, take_br, keep, wr_ok;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [4:0]        dest_q, dest_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              br_q, br_d;
  logic [DATA_W-1:0] br_pc_q, br_pc_d;

  exc_ctrl #(
    .DATA_W    (DATA_W),
    .OVF_CAUSE (OVF_CAUSE)
  ) u_exc_ctrl (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .trap         (trap),
    .trap_pc      (ex_pc),
    .exc_ack      (exc_ack),
    .state_o      (exc_state),
    .flush_req    (flush_req),
    .exc_pending  (exc_pending),
    .exc_redirect (exc_redirect),
    .epc          (epc),
    .exc_cause    (exc_cause)
  );

  // Slot qualification, write resolution and next values of the stage registers.
  // Slots arriving in TRAP as well as HOLD are squashed: they are younger than
  // the trapping instruction. Results are zeroed only when a decoded write was
  // suppressed, so store addresses (no decoded write) pass through intact.
  always_comb begin
    load      = !stall || flush;
    slot_live = ex_valid && !flush && (exc_state == RUN);
    trap      = load && slot_live && ex_trap_ovf && ex_overflow && !ex_is_branch;
    take_br   = load && slot_live && ex_is_branch && ex_alu_zero;
    keep      = slot_live && !trap;
    wr_ok     = keep && ex_reg_write && (!ex_is_movn || ex_movn) && (ex_dest_reg != '0);

    valid_d = valid_q;
    alu_d   = alu_q;
    store_d = store_q;
    dest_d  = dest_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    br_d    = br_q;
    br_pc_d = br_pc_q;
    if (load) begin
      valid_d = keep;
      rw_d    = wr_ok;
      mr_d    = keep && ex_mem_read;
      mw_d    = keep && ex_mem_write;
      dest_d  = keep ? ex_dest_reg : '0;
      alu_d   = (!keep || (ex_reg_write && !wr_ok)) ? '0 : ex_alu_result;
      store_d = keep ? ex_store_data : '0;
      br_d    = take_br;
      br_pc_d = take_br ? ex_branch_target : '0;
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      store_q <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      br_pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      br_pc_q <= br_pc_d;
    end
  end

  // Redirect merge: trap vector in TRAP, else the registered branch pulse
  always_comb begin
    redirect_valid = exc_redirect || (br_q && !stall);
    redirect_pc    = exc_redirect ? EXC_VECTOR : br_pc_q;
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = store_q;
  assign mem_dest_reg   = dest_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;

`ifdef EX_MEM_STATS_EN
  logic [31:0] retired_q, retired_d;
  logic [15:0] ovf_q, ovf_d;

  // Saturating retired-instruction and overflow-trap counters
  always_comb begin
    retired_d = retired_q;
    ovf_d     = ovf_q;
    if (load && valid_d && (retired_q != '1)) retired_d = retired_q + 32'd1;
    if (trap && (ovf_q != '1))                ovf_d     = ovf_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      ovf_q     <= '0;
    end else begin
      retired_q <= retired_d;
      ovf_q     <= ovf_d;
    end
  end

  assign retired_cnt  = retired_q;
  assign ovf_trap_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expectations.
// Define EX_MEM_STATS_EN to also check the statistics counters.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [31:0] ex_pc, ex_alu_result, ex_branch_target, ex_store_data;
  logic        ex_alu_zero, ex_movn, ex_overflow, ex_is_branch, ex_is_movn;
  logic        ex_trap_ovf, ex_reg_write, ex_mem_read, ex_mem_write, exc_ack;
  logic [4:0]  ex_dest_reg;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_store_data, redirect_pc, epc;
  logic [4:0]  mem_dest_reg, exc_cause;
  logic        redirect_valid, flush_req, exc_pending;
`ifdef EX_MEM_STATS_EN
  logic [31:0] retired_cnt;
  logic [15:0] ovf_trap_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .DATA_W     (32),
    .EXC_VECTOR (32'h8000_0180),
    .OVF_CAUSE  (5'd12)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_alu_result    (ex_alu_result),
    .ex_alu_zero      (ex_alu_zero),
    .ex_movn          (ex_movn),
    .ex_overflow      (ex_overflow),
    .ex_is_branch     (ex_is_branch),
    .ex_is_movn       (ex_is_movn),
    .ex_trap_ovf      (ex_trap_ovf),
    .ex_branch_target (ex_branch_target),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_store_data    (ex_store_data),
    .ex_dest_reg      (ex_dest_reg),
    .exc_ack          (exc_ack),
    .mem_valid        (mem_valid),
    .mem_alu_result   (mem_alu_result),
    .mem_store_data   (mem_store_data),
    .mem_dest_reg     (mem_dest_reg),
    .mem_reg_write    (mem_reg_write),
    .mem_mem_read     (mem_mem_read),
    .mem_mem_write    (mem_mem_write),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_req        (flush_req),
    .exc_pending      (exc_pending),
    .epc              (epc),
    .exc_cause        (exc_cause)
`ifdef EX_MEM_STATS_EN
    ,
    .retired_cnt      (retired_cnt),
    .ovf_trap_cnt     (ovf_trap_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; ex_pc = '0; ex_alu_result = '0;
    ex_alu_zero = 0; ex_movn = 0; ex_overflow = 0; ex_is_branch = 0;
    ex_is_movn = 0; ex_trap_ovf = 0; ex_branch_target = '0; ex_reg_write = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_store_data = '0; ex_dest_reg = '0;
    exc_ack = 0;
  endtask

  task automatic alu_op(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
    idle();
    ex_valid = 1; ex_pc = pc; ex_alu_result = res; ex_dest_reg = rd; ex_reg_write = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("rst_valid",   {31'd0, mem_valid},      32'd0);
    chk("rst_pending", {31'd0, exc_pending},    32'd0);
    chk("rst_redir",   {31'd0, redirect_valid}, 32'd0);
    chk("rst_epc",     epc,                     32'd0);
    rst = 0;

    // ADD -> 7 into r5
    alu_op(32'h0040_0000, 32'h0000_0007, 5'd5);
    tick();
    chk("add_valid",  {31'd0, mem_valid},     32'd1);
    chk("add_result", mem_alu_result,         32'd7);
    chk("add_wr",     {31'd0, mem_reg_write}, 32'd1);
    chk("add_dest",   {27'd0, mem_dest_reg},  32'd5);

    // MOVN not taken
    alu_op(32'h0040_0004, 32'h0000_DEAD, 5'd3);
    ex_is_movn = 1; ex_movn = 0;
    tick();
    chk("movn0_wr",     {31'd0, mem_reg_write}, 32'd0);
    chk("movn0_result", mem_alu_result,         32'd0);
    chk("movn0_valid",  {31'd0, mem_valid},     32'd1);

    // MOVN taken
    alu_op(32'h0040_0008, 32'h0000_ABCD, 5'd3);
    ex_is_movn = 1; ex_movn = 1;
    tick();
    chk("movn1_wr",     {31'd0, mem_reg_write}, 32'd1);
    chk("movn1_result", mem_alu_result,         32'h0000_ABCD);

    // Write to r0 is dropped
    alu_op(32'h0040_000C, 32'h0000_0011, 5'd0);
    tick();
    chk("r0_wr",     {31'd0, mem_reg_write}, 32'd0);
    chk("r0_result", mem_alu_result,         32'd0);

    // Taken BEQ with overflow flag must redirect, not trap
    idle();
    ex_valid = 1; ex_pc = 32'h0040_0014; ex_is_branch = 1; ex_alu_zero = 1;
    ex_branch_target = 32'h0040_0020; ex_overflow = 1; ex_trap_ovf = 1;
    tick();
    chk("br_redir",   {31'd0, redirect_valid}, 32'd1);
    chk("br_pc",      redirect_pc,             32'h0040_0020);
    chk("br_wr",      {31'd0, mem_reg_write},  32'd0);
    chk("br_nopend",  {31'd0, flush_req},      32'd0);
    idle();
    tick();
    chk("br_pulse_end", {31'd0, redirect_valid}, 32'd0);
    chk("br_notrap",    {31'd0, exc_pending},    32'd0);

    // ADD overflow trap
    alu_op(32'h0040_0010, 32'h0000_0005, 5'd8);
    ex_overflow = 1; ex_trap_ovf = 1;
    tick();
    chk("trap_bubble", {31'd0, mem_valid},      32'd0);
    chk("trap_nowr",   {31'd0, mem_reg_write},  32'd0);
    chk("trap_redir",  {31'd0, redirect_valid}, 32'd1);
    chk("trap_vec",    redirect_pc,             32'h8000_0180);
    chk("trap_flush",  {31'd0, flush_req},      32'd1);
    chk("trap_epc",    epc,                     32'h0040_0010);
    chk("trap_cause",  {27'd0, exc_cause},      32'd12);
    alu_op(32'h0040_0014, 32'h0000_0055, 5'd9);
    tick();
    chk("hold_pend",   {31'd0, exc_pending},    32'd1);
    chk("hold_redir",  {31'd0, redirect_valid}, 32'd0);
    chk("hold_flush",  {31'd0, flush_req},      32'd0);
    chk("trapslot_v",  {31'd0, mem_valid},      32'd0);
    tick();
    chk("hold_bubble", {31'd0, mem_valid},      32'd0);
    chk("hold_pend2",  {31'd0, exc_pending},    32'd1);
    idle();
    exc_ack = 1;
    tick();
    chk("ack_pend",    {31'd0, exc_pending},    32'd0);
    chk("ack_epc",     epc,                     32'h0040_0010);
    chk("ack_cause",   {27'd0, exc_cause},      32'd12);
    exc_ack = 0;

    // Stall holds the stage; stall with flush loads a bubble
    alu_op(32'h0040_0100, 32'h0000_1234, 5'd6);
    tick();
    chk("pre_stall", mem_alu_result, 32'h0000_1234);
    alu_op(32'h0040_0104, 32'h0000_9999, 5'd7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", mem_alu_result,        32'h0000_1234);
      chk("stall_dest",   {27'd0, mem_dest_reg}, 32'd6);
      chk("stall_valid",  {31'd0, mem_valid},    32'd1);
    end
    flush = 1;
    tick();
    chk("sflush_valid", {31'd0, mem_valid},     32'd0);
    chk("sflush_wr",    {31'd0, mem_reg_write}, 32'd0);
    chk("sflush_dest",  {27'd0, mem_dest_reg},  32'd0);

    // Second trap, then reset while in HOLD
    alu_op(32'h0040_0200, 32'h0000_0001, 5'd4);
    ex_overflow = 1; ex_trap_ovf = 1;
    tick();
    idle();
    tick();
    chk("hold2_pend", {31'd0, exc_pending}, 32'd1);
`ifdef EX_MEM_STATS_EN
    chk("stat_retired", retired_cnt,           32'd6);
    chk("stat_ovf",     {16'd0, ovf_trap_cnt}, 32'd2);
`endif
    rst = 1;
    tick();
    chk("rst2_pend",  {31'd0, exc_pending},    32'd0);
    chk("rst2_epc",   epc,                     32'd0);
    chk("rst2_cause", {27'd0, exc_cause},      32'd0);
    chk("rst2_valid", {31'd0, mem_valid},      32'd0);
    chk("rst2_redir", {31'd0, redirect_valid}, 32'd0);
`ifdef EX_MEM_STATS_EN
    chk("rst2_retired", retired_cnt,           32'd0);
    chk("rst2_ovf",     {16'd0, ovf_trap_cnt}, 32'd0);
`endif
    rst = 0;
    // FSM back in RUN: a fresh instruction flows
    alu_op(32'h0040_0300, 32'h0000_0042, 5'd2);
    tick();
    chk("post_rst_result", mem_alu_result,     32'h0000_0042);
    chk("post_rst_valid",  {31'd0, mem_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the execute ALU.
- Registers the ALU result and control sideband, and resolves the final register write enable (MOVN gating, overflow suppression).
- Resolves taken branches into a single PC redirect and runs a small exception FSM that captures arithmetic-overflow traps (EPC/cause) and holds the pipe until acknowledged.

Parameters:
- DATA_W, 32, datapath and PC width
- EXC_VECTOR, 32'h8000_0180, redirect PC on overflow trap
- OVF_CAUSE, 5'd12, cause code written on overflow trap

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble into the stage
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  DATA_W  PC of EX instruction
- ex_alu_result  in  DATA_W  ALU result
- ex_alu_zero  in  1  ALU branch condition
- ex_movn  in  1  ALU MOVN write-permit
- ex_overflow  in  1  ALU overflow flag
- ex_is_branch  in  1  instruction is a conditional branch
- ex_is_movn  in  1  instruction is MOVN
- ex_trap_ovf  in  1  instruction traps on overflow (ADD/SUB, ADDI)
- ex_branch_target  in  DATA_W  computed branch target
- ex_reg_write  in  1  decoded register write enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_store_data  in  DATA_W  rt value for stores
- ex_dest_reg  in  5  destination register
- exc_ack  in  1  exception handler acknowledge
- mem_valid  out  1  MEM slot valid
- mem_alu_result  out  DATA_W  registered result / address
- mem_store_data  out  DATA_W  registered store data
- mem_dest_reg  out  5  registered destination
- mem_reg_write  out  1  resolved write enable
- mem_mem_read  out  1  registered load
- mem_mem_write  out  1  registered store
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  DATA_W  redirect target
- flush_req  out  1  flush IF/ID/EX (one cycle)
- exc_pending  out  1  trap held, awaiting exc_ack
- epc  out  DATA_W  PC of trapping instruction
- exc_cause  out  5  trap cause code

Behaviour:
- Reset (synchronous, active-high, on the rising clk edge):
  - all outputs 0; epc 0; exc_cause 0; FSM to RUN.
- Advance condition: the stage loads on a clk edge when stall=0. With stall=1, all registers hold and redirect_valid/flush_req are 0.
- Bubble: flush=1 or ex_valid=0 loads mem_valid=0 and clears reg_write, mem_read, mem_write and dest to 0. flush beats stall.
- Write resolution:
  - mem_reg_write = ex_reg_write & (!ex_is_movn | ex_movn) & !trap & (ex_dest_reg!=0).
  - When the write is suppressed, mem_alu_result loads 0. This keeps X values from the ALU default and MOVN-not-taken cases out of the pipe.
- Trap condition: ex_valid & ex_trap_ovf & ex_overflow & !ex_is_branch, in RUN, on an advancing edge.
  - Overflow on branches (BEQ/BNE use the ALU subtract) is ignored.
  - Overflow on invalid slots is ignored.
- Branch: ex_valid & ex_is_branch & ex_alu_zero on an advancing edge gives redirect_valid=1 and redirect_pc=ex_branch_target for exactly one cycle (registered, latency 1).
- FSM:
  - RUN: on trap, load epc=ex_pc and exc_cause=OVF_CAUSE, insert a bubble (mem_valid=0, no writes), and go to TRAP.
  - TRAP (1 cycle): redirect_valid=1, redirect_pc=EXC_VECTOR, flush_req=1, then go to HOLD.
  - HOLD: exc_pending=1; every incoming slot is forced to a bubble regardless of ex_valid. On exc_ack=1, go to RUN and clear exc_pending the next cycle; epc and exc_cause are retained.
- Simultaneous events:
  - Trap and branch redirect never coincide (branches are excluded from trapping).
  - exc_ack while in RUN or TRAP is ignored.
  - rst during TRAP or HOLD returns to RUN with all outputs cleared.
  - stall asserted in TRAP holds the TRAP state and defers the redirect pulse.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined: adds outputs retired_cnt (32 bit) and ovf_trap_cnt (16 bit).
  - retired_cnt increments on each advancing edge that loads mem_valid=1.
  - ovf_trap_cnt increments on each RUN->TRAP transition.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg: exception cause codes (OVF_CAUSE value), EXC_VECTOR, FSM state enum {RUN, TRAP, HOLD}.
- One sub-module: exc_ctrl, containing the FSM plus the epc/exc_cause registers, with trap/exc_ack/stall in and state, flush_req, exc_pending and redirect select out.

Test Plan:
- ADD result 32'h0000_0007, dest 5, reg_write=1, no stall: next cycle mem_alu_result=7, mem_reg_write=1, mem_dest_reg=5.
- MOVN with ex_movn=0: mem_reg_write=0 and mem_alu_result=0. Repeat with ex_movn=1 and result 32'hABCD: write=1, result 32'hABCD.
- BEQ with ex_alu_zero=1 and target 32'h0040_0020: one-cycle redirect_valid with redirect_pc=32'h0040_0020. Same inputs with ex_overflow=1 must not trap.
- ADD at pc 32'h0040_0010 with overflow and trap_ovf=1:
  - mem_valid=0, then a TRAP cycle with redirect_pc=32'h8000_0180 and flush_req=1.
  - epc=32'h0040_0010, exc_cause=12, exc_pending held until exc_ack.
- stall=1 held for 3 cycles during a valid instruction: outputs unchanged. stall=1 together with flush=1: bubble loaded.
- rst asserted in HOLD: next cycle FSM in RUN and all outputs 0. With EX_MEM_STATS_EN, counters read 0.
